// File: rtl/mpu_matrix_loader.sv
// Matrix loader. It collects a stream of 8-bit elements into two 5x5 matrices,
// A first and then B, and presents the pair to the subtract stage.
// Element k = row + 5*col sits at bits [8k +: 8] of its matrix.
//
// Handshakes (valid/ready):
//   An input element transfers on a rising edge where in_valid && in_ready.
//   in_ready depends only on the registered state and never on in_valid.
//   The matrix pair is handed off on a rising edge where mat_valid && mat_ready.
//   mat_valid stays high, and both matrices stay constant, until that edge.
module mpu_matrix_loader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic [199:0] matrix_a,
  output logic [199:0] matrix_b,
  output logic         mat_valid,
  input  logic         mat_ready,
  output logic         frame_err,
  output logic [4:0]   elem_idx,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        ferr_q, ferr_d;
  logic        wr_a, wr_b;
  logic        xfer;
  logic        at_end;
  logic        err;
  logic [7:0]  bit_base;

  assign in_ready  = (state_q != FULL);
  assign mat_valid = (state_q == FULL);
  assign frame_err = ferr_q;
  assign elem_idx  = idx_q;
  assign state_dbg = state_q;

  assign xfer     = in_valid & in_ready;
  // Only B element 24 may carry in_last, and that element must carry it.
  assign at_end   = (state_q == LOAD_B) && (idx_q == 5'd24);
  assign err      = xfer & (in_last != at_end);
  assign bit_base = {idx_q, 3'b000};

  // Next-state, element index and write-enable decode; clear overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ferr_d  = 1'b0;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    if (clear) begin
      state_d = LOAD_A;
      idx_d   = 5'd0;
    end else if (err) begin
      // The offending element is dropped and the pair restarts from A element 0.
      ferr_d  = 1'b1;
      state_d = LOAD_A;
      idx_d   = 5'd0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (xfer) begin
            wr_a = 1'b1;
            if (idx_q == 5'd24) begin
              state_d = LOAD_B;
              idx_d   = 5'd0;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
        LOAD_B: begin
          if (xfer) begin
            wr_b = 1'b1;
            if (idx_q == 5'd24) begin
              state_d = FULL;
              idx_d   = 5'd0;
            end else begin
              idx_d = idx_q + 5'd1;
            end
          end
        end
        FULL: begin
          if (mat_ready) begin
            state_d = LOAD_A;
            idx_d   = 5'd0;
          end
        end
        default: begin
          state_d = LOAD_A;
          idx_d   = 5'd0;
        end
      endcase
    end
  end

  // State, index, error pulse and matrix storage; matrices are written one byte at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD_A;
      idx_q    <= 5'd0;
      ferr_q   <= 1'b0;
      matrix_a <= '0;
      matrix_b <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ferr_q  <= ferr_d;
      if (wr_a) matrix_a[bit_base +: 8] <= in_data;
      if (wr_b) matrix_b[bit_base +: 8] <= in_data;
    end
  end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Bench for mpu_matrix_loader. The reference model tracks the position within
// a 50-element pair and keeps both matrices as plain byte arrays.
module tb_mpu_matrix_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_ready;
  logic [199:0] matrix_a;
  logic [199:0] matrix_b;
  logic         mat_valid;
  logic         mat_ready;
  logic         frame_err;
  logic [4:0]   elem_idx;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  logic [7:0] m_a [25];
  logic [7:0] m_b [25];
  int         m_pos;
  bit         m_full;
  bit         m_ferr;

  // clock and reset
  always #5 clk = ~clk;

  mpu_matrix_loader dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .matrix_a(matrix_a), .matrix_b(matrix_b),
    .mat_valid(mat_valid), .mat_ready(mat_ready),
    .frame_err(frame_err), .elem_idx(elem_idx), .state_dbg(state_dbg)
  );

  function automatic logic [199:0] exp_a();
    logic [199:0] r;
    for (int k = 0; k < 25; k++) r[8*k +: 8] = m_a[k];
    return r;
  endfunction

  function automatic logic [199:0] exp_b();
    logic [199:0] r;
    for (int k = 0; k < 25; k++) r[8*k +: 8] = m_b[k];
    return r;
  endfunction

  function automatic logic [4:0] exp_idx();
    return 5'(m_pos % 25);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 25; k++) begin
      m_a[k] = 8'd0;
      m_b[k] = 8'd0;
    end
    m_pos  = 0;
    m_full = 1'b0;
    m_ferr = 1'b0;
  endtask

  // driver: one clock cycle of stimulus; returns 1 time unit after the edge
  task automatic drive_cycle(input bit v, input logic [7:0] d, input bit l,
                             input bit mr, input bit clr);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    mat_ready = mr;
    clear     = clr;
    @(posedge clk);
    m_ferr = 1'b0;
    if (clr) begin
      m_pos  = 0;
      m_full = 1'b0;
    end else if (m_full) begin
      if (mr) begin
        m_full = 1'b0;
        m_pos  = 0;
      end
    end else if (v) begin
      if (l != (m_pos == 49)) begin
        m_ferr = 1'b1;
        m_pos  = 0;
      end else begin
        if (m_pos < 25) m_a[m_pos] = d;
        else            m_b[m_pos - 25] = d;
        if (m_pos == 49) begin
          m_full = 1'b1;
          m_pos  = 0;
        end else begin
          m_pos++;
        end
      end
    end
    #1;
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++)
      drive_cycle(1'b1, 8'($urandom_range(0, 255)), (m_pos == 49), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    in_last = 1'b0; mat_ready = 1'b0;
    model_reset();
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (mat_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mat_valid got=%b want=0", mat_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    n_cmp++; if (elem_idx !== 5'd0) begin n_bad++; $display("FAIL reset_elem_idx got=%0d want=0", elem_idx); end
    n_cmp++; if (matrix_a !== 200'd0 || matrix_b !== 200'd0) begin n_bad++; $display("FAIL reset_matrices got a=%h b=%h want 0", matrix_a, matrix_b); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_pair();
    for (int i = 0; i < 50; i++) begin
      drive_cycle(1'b1, (i < 25) ? 8'(i + 1) : 8'(50 - i), (i == 49), 1'b0, 1'b0);
      n_cmp++; if (elem_idx !== exp_idx()) begin n_bad++; $display("FAIL basic_idx step=%0d got=%0d want=%0d", i, elem_idx, exp_idx()); end
      n_cmp++; if (mat_valid !== m_full) begin n_bad++; $display("FAIL basic_mat_valid step=%0d got=%b want=%b", i, mat_valid, m_full); end
    end
    n_cmp++; if (mat_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_full got mv=%b rdy=%b want 1/0", mat_valid, in_ready); end
    n_cmp++; if (matrix_a[7:0] !== 8'd1 || matrix_a[199:192] !== 8'd25) begin n_bad++; $display("FAIL basic_a_ends got %0d,%0d want 1,25", matrix_a[7:0], matrix_a[199:192]); end
    n_cmp++; if (matrix_b[7:0] !== 8'd25 || matrix_b[199:192] !== 8'd1) begin n_bad++; $display("FAIL basic_b_ends got %0d,%0d want 25,1", matrix_b[7:0], matrix_b[199:192]); end
    n_cmp++; if (int'(matrix_a[103:96]) - int'(matrix_b[103:96]) !== 0) begin n_bad++; $display("FAIL basic_sub12 got a=%0d b=%0d want diff 0", matrix_a[103:96], matrix_b[103:96]); end
    n_cmp++; if (matrix_a !== exp_a() || matrix_b !== exp_b()) begin n_bad++; $display("FAIL basic_layout got a=%h b=%h want a=%h b=%h", matrix_a, matrix_b, exp_a(), exp_b()); end
  endtask

  task automatic test_hold_full();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (in_ready !== 1'b0 || mat_valid !== 1'b1) begin n_bad++; $display("FAIL hold_flags cyc=%0d got rdy=%b mv=%b want 0/1", i, in_ready, mat_valid); end
      n_cmp++; if (matrix_a !== exp_a() || matrix_b !== exp_b()) begin n_bad++; $display("FAIL hold_matrices cyc=%0d got a=%h b=%h", i, matrix_a, matrix_b); end
    end
    drive_cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (mat_valid !== 1'b0 || in_ready !== 1'b1 || elem_idx !== 5'd0) begin n_bad++; $display("FAIL hold_release got mv=%b rdy=%b idx=%0d want 0/1/0", mat_valid, in_ready, elem_idx); end
    n_cmp++; if (matrix_a !== exp_a() || matrix_b !== exp_b()) begin n_bad++; $display("FAIL hold_retain got a=%h b=%h", matrix_a, matrix_b); end
  endtask

  task automatic test_frame_early();
    logic [7:0] old7;
    send_random(7);
    old7 = m_a[7];
    drive_cycle(1'b1, old7 ^ 8'hA5, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (frame_err !== 1'b1 || elem_idx !== 5'd0) begin n_bad++; $display("FAIL early_err got ferr=%b idx=%0d want 1/0", frame_err, elem_idx); end
    n_cmp++; if (matrix_a[63:56] !== old7) begin n_bad++; $display("FAIL early_nowrite got=%h want=%h", matrix_a[63:56], old7); end
    drive_cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL early_pulse got=%b want=0", frame_err); end
    send_random(50);
    n_cmp++; if (mat_valid !== 1'b1 || matrix_a !== exp_a() || matrix_b !== exp_b()) begin n_bad++; $display("FAIL early_reload got mv=%b a=%h b=%h", mat_valid, matrix_a, matrix_b); end
    drive_cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_missing_last();
    logic [7:0] old24;
    send_random(49);
    old24 = m_b[24];
    drive_cycle(1'b1, old24 ^ 8'hFF, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (frame_err !== 1'b1 || mat_valid !== 1'b0) begin n_bad++; $display("FAIL nolast_err got ferr=%b mv=%b want 1/0", frame_err, mat_valid); end
    n_cmp++; if (matrix_b[199:192] !== old24 || elem_idx !== 5'd0) begin n_bad++; $display("FAIL nolast_nowrite got b24=%h idx=%0d want %h/0", matrix_b[199:192], elem_idx, old24); end
  endtask

  task automatic test_clear();
    logic [7:0] old10;
    send_random(35);
    old10 = m_b[10];
    drive_cycle(1'b1, old10 ^ 8'h5A, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (elem_idx !== 5'd0 || in_ready !== 1'b1 || mat_valid !== 1'b0) begin n_bad++; $display("FAIL clear_b10 got idx=%0d rdy=%b mv=%b want 0/1/0", elem_idx, in_ready, mat_valid); end
    n_cmp++; if (matrix_b[87:80] !== old10 || matrix_a !== exp_a()) begin n_bad++; $display("FAIL clear_retain got b10=%h want=%h", matrix_b[87:80], old10); end
    send_random(50);
    drive_cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (mat_valid !== 1'b0 || in_ready !== 1'b1 || elem_idx !== 5'd0) begin n_bad++; $display("FAIL clear_handshake got mv=%b rdy=%b idx=%0d want 0/1/0", mat_valid, in_ready, elem_idx); end
    send_random(50);
    drive_cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (mat_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL clear_full got mv=%b rdy=%b want 0/1", mat_valid, in_ready); end
    n_cmp++; if (matrix_a !== exp_a() || matrix_b !== exp_b()) begin n_bad++; $display("FAIL clear_full_retain got a=%h b=%h", matrix_a, matrix_b); end
  endtask

  task automatic test_async_reset();
    send_random(30);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (matrix_a !== 200'd0 || matrix_b !== 200'd0) begin n_bad++; $display("FAIL areset_matrices got a=%h b=%h want 0", matrix_a, matrix_b); end
    n_cmp++; if (elem_idx !== 5'd0 || mat_valid !== 1'b0 || in_ready !== 1'b1 || frame_err !== 1'b0) begin n_bad++; $display("FAIL areset_flags got idx=%0d mv=%b rdy=%b ferr=%b", elem_idx, mat_valid, in_ready, frame_err); end
    @(negedge clk);
    rst_n = 1'b1;
    send_random(50);
    n_cmp++; if (mat_valid !== 1'b1 || matrix_a !== exp_a() || matrix_b !== exp_b()) begin n_bad++; $display("FAIL areset_reload got mv=%b a=%h b=%h", mat_valid, matrix_a, matrix_b); end
    drive_cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit v, l, mr, clr;
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 9) < 8);
      l   = (m_pos == 49) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 39) == 0);
      mr  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 49) == 0);
      drive_cycle(v, 8'($urandom_range(0, 255)), l, mr, clr);
      n_cmp++;
      if (in_ready !== !m_full || mat_valid !== m_full || elem_idx !== exp_idx() || frame_err !== m_ferr) begin
        n_bad++;
        $display("FAIL rand_ctrl cyc=%0d got rdy=%b mv=%b idx=%0d ferr=%b want %b/%b/%0d/%b",
                 i, in_ready, mat_valid, elem_idx, frame_err, !m_full, m_full, exp_idx(), m_ferr);
      end
      n_cmp++;
      if (matrix_a !== exp_a() || matrix_b !== exp_b()) begin
        n_bad++;
        $display("FAIL rand_data cyc=%0d got a=%h b=%h want a=%h b=%h", i, matrix_a, matrix_b, exp_a(), exp_b());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_hold_full();
    test_frame_early();
    test_missing_last();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
